// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage macros, state encoding and default widths.
// Macros are guarded so a later shared header may define them first.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef PC_STEP
`define PC_STEP 2
`endif
`ifndef RESET_PC
`define RESET_PC 0
`endif
`ifndef IF_IDLE
`define IF_IDLE 2'd0
`endif
`ifndef IF_RUN
`define IF_RUN 2'd1
`endif
`ifndef IF_HALT
`define IF_HALT 2'd2
`endif

package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IF_ST_IDLE = `IF_IDLE,
        IF_ST_RUN  = `IF_RUN,
        IF_ST_HALT = `IF_HALT
    } fetch_state_t;

    localparam int DEF_ADDR_W   = `ADDR_SIZE;
    localparam int DEF_WORD_W   = `WORD_SIZE;
    localparam int DEF_PC_STEP  = `PC_STEP;
    localparam int DEF_RESET_PC = `RESET_PC;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO: DEPTH x DAT_W, push/pop/flush, combinational head.
// Latency: pushed entry visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full without a pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int DAT_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DAT_W-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DAT_W-1:0]         head_dat
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC/state control driving a combinational ROM into a prefetch FIFO.
// Latency: rom_addr = pc; word captured at that edge, valid to decode the next cycle.
// Backpressure: fetch stalls (pc holds) when the FIFO is full and decode does not pop.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int PC_STEP  = DEF_PC_STEP,
    parameter int DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic              misalign
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);

    fetch_state_t             state;
    logic [ADDR_W-1:0]        pc;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W+WORD_W-1:0] head_dat;
    logic                     pop;
    logic                     push;

    // Redirect suppresses both sides of the FIFO so the flush wins cleanly.
    assign pop  = instr_valid & instr_ready & ~redirect_valid;
    assign push = (state == IF_ST_RUN) & ~redirect_valid & ~halt &
                  ((count < CNT_W'(DEPTH)) | pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .DAT_W (ADDR_W + WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({pc, rom_data}),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head_dat (head_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IF_ST_IDLE;
            pc       <= ADDR_W'(RESET_PC);
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (redirect_valid) begin
                pc       <= redirect_pc & ~STEP_MASK;
                misalign <= |(redirect_pc & STEP_MASK);
                if (state == IF_ST_HALT) state <= IF_ST_RUN;
            end else begin
                if (push) pc <= pc + ADDR_W'(PC_STEP);
                case (state)
                    IF_ST_IDLE: if (start) state <= IF_ST_RUN;
                    IF_ST_RUN:  if (halt)  state <= IF_ST_HALT;
                    default:    state <= state;
                endcase
            end
        end
    end

    assign rom_addr    = pc;
    assign instr_valid = (count != '0);
    assign halted      = (state == IF_ST_HALT) && (count == '0);
    assign instr_data  = head_dat[WORD_W-1:0];
    assign instr_pc    = head_dat[ADDR_W+WORD_W-1 -: ADDR_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: queue-based reference model checked every
// falling edge, plus literal expectations from the hand-worked scenarios.
module tb_instr_fetch;
    localparam int AW = 8;
    localparam int WW = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic [WW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          halted;
    logic          misalign;

    logic [WW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .WORD_W(WW), .RESET_PC(0), .PC_STEP(2), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .misalign       (misalign)
    );

    // Reference model: 0 idle, 1 run, 2 halt; FIFO as a queue of {pc,word}.
    int        m_state = 0;
    int        m_pc = 0;
    bit        m_mis = 1'b0;
    logic [AW+WW-1:0] m_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_pc    = 0;
            m_mis   = 1'b0;
            m_q.delete();
        end else if (redirect_valid) begin
            m_q.delete();
            m_mis = (int'(redirect_pc) % 2) != 0;
            m_pc  = int'(redirect_pc) - (int'(redirect_pc) % 2);
            if (m_state == 2) m_state = 1;
        end else begin
            bit popped;
            bit pushed;
            m_mis  = 1'b0;
            popped = (m_q.size() > 0) && instr_ready;
            pushed = (m_state == 1) && !halt && ((m_q.size() < DEPTH) || popped);
            if (popped) void'(m_q.pop_front());
            if (pushed) begin
                m_q.push_back({m_pc[AW-1:0], rom[m_pc]});
                m_pc = (m_pc + 2) % 256;
            end
            if (m_state == 0 && start) m_state = 1;
            else if (m_state == 1 && halt) m_state = 2;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model rom_addr", int'(rom_addr), m_pc);
        chk("model instr_valid", int'(instr_valid), int'(m_q.size() != 0));
        chk("model halted", int'(halted), int'(m_state == 2 && m_q.size() == 0));
        chk("model misalign", int'(misalign), int'(m_mis));
        if (m_q.size() != 0 && instr_valid) begin
            chk("model instr_pc", int'(instr_pc), int'(m_q[0][AW+WW-1:WW]));
            chk("model instr_data", int'(instr_data), int'(m_q[0][WW-1:0]));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic redirect_to(input int target);
        redirect_valid = 1'b1;
        redirect_pc    = AW'(target);
        tick(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = WW'(16'h1000 + a * 3);
        rom[0] = 16'h0000;
        rom[2] = 16'h0005;
        rom[4] = 16'h0003;

        #2;
        chk("reset rom_addr", int'(rom_addr), 0);
        chk("reset instr_valid", int'(instr_valid), 0);
        chk("reset halted", int'(halted), 0);
        chk("reset misalign", int'(misalign), 0);
        tick(2);
        rst_n = 1'b1;

        // Streaming fetch with decode always ready.
        instr_ready = 1'b1;
        pulse_start();
        chk("stream idle-run valid", int'(instr_valid), 0);
        tick(1);
        chk("stream pc0", int'(instr_pc), 0);
        chk("stream data0", int'(instr_data), 16'h0000);
        chk("stream addr2", int'(rom_addr), 2);
        tick(1);
        chk("stream pc2", int'(instr_pc), 2);
        chk("stream data2", int'(instr_data), 16'h0005);
        chk("stream addr4", int'(rom_addr), 4);
        tick(1);
        chk("stream pc4", int'(instr_pc), 4);
        chk("stream data4", int'(instr_data), 16'h0003);
        chk("stream addr6", int'(rom_addr), 6);

        // Backpressure: buffer fills to DEPTH, then drains without gaps.
        do_reset();
        pulse_start();
        tick(4);
        chk("full rom_addr hold", int'(rom_addr), 4);
        chk("full head pc", int'(instr_pc), 0);
        instr_ready = 1'b1;
        tick(1);
        chk("drain head pc2", int'(instr_pc), 2);
        chk("drain valid", int'(instr_valid), 1);
        tick(1);
        chk("drain head pc4", int'(instr_pc), 4);
        chk("drain head data4", int'(instr_data), 16'h0003);

        // Redirect flushes a full buffer.
        do_reset();
        pulse_start();
        tick(3);
        redirect_to(4);
        chk("redir flush valid", int'(instr_valid), 0);
        chk("redir rom_addr", int'(rom_addr), 4);
        tick(1);
        chk("redir new pc", int'(instr_pc), 4);
        chk("redir new data", int'(instr_data), 16'h0003);
        redirect_to(3);
        chk("misalign pulse", int'(misalign), 1);
        chk("misalign addr", int'(rom_addr), 2);
        tick(1);
        chk("misalign one-shot", int'(misalign), 0);

        // Halt drains the buffer and freezes the PC.
        do_reset();
        pulse_start();
        tick(3);
        halt = 1'b1;
        instr_ready = 1'b1;
        tick(1);
        halt = 1'b0;
        chk("halt head pc2", int'(instr_pc), 2);
        chk("halt not yet halted", int'(halted), 0);
        tick(1);
        chk("halted after drain", int'(halted), 1);
        chk("halt rom_addr frozen", int'(rom_addr), 4);
        tick(2);
        chk("halt still frozen", int'(rom_addr), 4);
        redirect_to(0);
        chk("resume halted clear", int'(halted), 0);
        chk("resume rom_addr", int'(rom_addr), 0);
        tick(1);
        chk("resume pc0", int'(instr_pc), 0);
        chk("resume valid", int'(instr_valid), 1);

        // PC wrap at the top of the address space.
        redirect_to(254);
        chk("wrap rom_addr 254", int'(rom_addr), 254);
        tick(1);
        chk("wrap rom_addr 0", int'(rom_addr), 0);
        chk("wrap head pc", int'(instr_pc), 254);
        tick(3);

        // Asynchronous reset mid-run with a full buffer.
        instr_ready = 1'b0;
        tick(3);
        chk("pre-rst full", int'(instr_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", int'(instr_valid), 0);
        chk("async rst rom_addr", int'(rom_addr), 0);
        tick(1);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        tick(3);
        chk("post-rst idle addr", int'(rom_addr), 0);
        chk("post-rst idle valid", int'(instr_valid), 0);
        pulse_start();
        tick(2);
        chk("post-rst restart pc", int'(instr_pc), 2);

        tick(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch initiator for the program ROM. Holds the program counter and drives the ROM address. Captures the combinational ROM data word and hands {pc, instruction} to the decode stage over a valid/ready handshake through a small prefetch buffer. Supports start, redirect (branch/jump) and halt-drain.

Parameters:
ADDR_W, `ADDR_SIZE, width of PC and ROM address
WORD_W, `WORD_SIZE, instruction word width
RESET_PC, 0, PC value after reset
PC_STEP, 2, PC increment per fetch (byte-addressed 16-bit words)
DEPTH, 2, prefetch buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; IDLE -> RUN
rom_addr  output  ADDR_W  ROM address, equals pc register
rom_data  input  WORD_W  ROM word for rom_addr, valid same cycle (combinational ROM)
instr_data  output  WORD_W  buffered instruction at head
instr_pc  output  ADDR_W  address instr_data was fetched from
instr_valid  output  1  head entry valid
instr_ready  input  1  decode accepts head this cycle
redirect_valid  input  1  load new PC and flush buffer
redirect_pc  input  ADDR_W  target PC
halt  input  1  stop fetching; drain buffer
halted  output  1  HALT state and buffer empty
misalign  output  1  one-cycle pulse: redirect_pc not PC_STEP-aligned

Behaviour:
- Reset (async, any time): state=IDLE, pc=RESET_PC, count=0, buffer pointers=0; instr_valid=0, halted=0, misalign=0. instr_data/instr_pc are don't-care while instr_valid=0 (reset to 0).
- rom_addr = pc at all times, no extra latency. Fetched word is captured at the same rising edge.
- States: IDLE, RUN, HALT (2-bit encoding).
  - IDLE: no pushes. start -> RUN.
  - RUN: halt -> HALT.
  - HALT: no pushes; buffer drains normally. redirect_valid -> RUN.
  - IDLE ignores halt.
- Push (RUN only, no redirect): when count<DEPTH, or count==DEPTH with a pop this cycle, write {pc, rom_data} at tail and set pc <= pc+PC_STEP, wrapping mod 2^ADDR_W. No push means pc holds.
- Pop: instr_valid && instr_ready. Head advances. instr_valid = (count!=0), registered.
- Simultaneous push+pop: count unchanged. Full buffer with pop gives full throughput of one instruction/cycle.
- Redirect (any state):
  - count<=0 and pc<=redirect_pc with low log2(PC_STEP) bits cleared. No push and no pop that cycle.
  - misalign pulses if any cleared bit was 1.
  - IDLE stays IDLE; RUN stays RUN; HALT goes to RUN.
  - instr_valid=0 the next cycle. First new instruction is valid 2 cycles after redirect.
- Priority: reset > redirect > halt > push/pop. halt and redirect together: redirect wins, state=RUN.
- halt in same cycle as a possible push: no push, pc holds.
- halted = (state==HALT) && (count==0), registered.
- rom_data X (unprogrammed address) is stored unchanged; no checking.
- Buffer pointers are log2(DEPTH) bits, wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Add to shared macro header top_macro.vh: `PC_STEP, `RESET_PC, fetch state encodings `IF_IDLE/`IF_RUN/`IF_HALT.
- Sub-module fetch_fifo: DEPTH x (ADDR_W+WORD_W) synchronous FIFO with push, pop, flush, count, head outputs, async active-low reset.
- instr_fetch contains the state machine, PC and redirect logic, and one fetch_fifo instance.

Test Plan:
- ROM words 0:0x0000, 2:0x0005, 4:0x0003; reset, start, instr_ready=1 -> instr_valid from cycle 2; {pc,data} = (0,0x0000),(2,0x0005),(4,0x0003) on consecutive cycles; rom_addr steps 0,2,4,6.
- instr_ready=0 after start -> exactly DEPTH=2 entries (pc 0,2) buffered, rom_addr holds 4. Ready=1 -> entries out in order, then pc 4 with 0x0003, no gaps.
- Redirect to 4 while buffer holds pc 0,2 -> instr_valid=0 next cycle; next output (4,0x0003). Redirect to 3 -> misalign pulse, fetch from 2.
- halt with 2 entries buffered, ready=1 -> entries 0,2 drain, rom_addr frozen, halted=1 after drain. Redirect to 0 -> RUN, fetch resumes at 0.
- pc at 2^ADDR_W-2, RUN -> next rom_addr wraps to 0.
- rst_n low mid-RUN with full buffer -> immediately instr_valid=0, rom_addr=0, IDLE. After release, no fetch until start.
